// File: rtl/toggle_event_decoder.sv
// Receives a toggle-encoded asynchronous event line, regenerates one pulse per
// transition and hands the accumulated event count out over valid/ready.
module toggle_event_decoder #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Toggle_in,
    output logic             Pulse,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [CNT_W-1:0] Out_count,
    output logic             Overflow
);

    localparam logic [0:0] ST_EMPTY   = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;
    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;

    logic event_w;
    logic transfer_w;

    assign event_w    = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign transfer_w = (state_q == ST_PENDING) && Out_ready;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], Toggle_in};
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = event_w;
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_EMPTY: begin
                if (event_w) begin
                    state_d = ST_PENDING;
                    count_d = CNT_ONE;
                end
            end
            default: begin
                // A transfer hands off the current count; a same-cycle event reloads it to 1.
                if (transfer_w) begin
                    ovf_d = 1'b0;
                    if (event_w) begin
                        count_d = CNT_ONE;
                    end else begin
                        count_d = '0;
                        state_d = ST_EMPTY;
                    end
                end else if (event_w) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            state_q <= ST_EMPTY;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Pulse     = pulse_q;
    assign Out_valid = (state_q == ST_PENDING);
    assign Out_count = count_q;
    assign Overflow  = ovf_q;

endmodule
